// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle for the scoreboarded register file.
// master = pipeline side, slave = register file.
interface regfile_scoreboard_if #(
    parameter int DEPTH = 32,
    parameter int BITS  = 64
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]   address1;
    logic [AW-1:0]   address2;
    logic [BITS-1:0] read1;
    logic [BITS-1:0] read2;
    logic            busy1;
    logic            busy2;
    logic [AW-1:0]   addressw;
    logic [BITS-1:0] writeData;
    logic            writeEn;
    logic            issueEn;
    logic [AW-1:0]   issueAddr;
    logic            issueStall;
    logic [AW:0]     pendingCount;

    modport master (
        output address1, address2, addressw, writeData,
        output writeEn, issueEn, issueAddr,
        input  read1, read2, busy1, busy2,
        input  issueStall, pendingCount
    );

    modport slave (
        input  address1, address2, addressw, writeData,
        input  writeEn, issueEn, issueAddr,
        output read1, read2, busy1, busy2,
        output issueStall, pendingCount
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file: 2 async reads, 1 sync write, optional bypass,
// hardwired zero register and a pending-write scoreboard for hazards.
module regfile_scoreboard #(
    parameter int DEPTH    = 32,
    parameter int BITS     = 64,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input logic                clk,
    input logic                rst,
    regfile_scoreboard_if.slave bus
);
    logic [BITS-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_pending;
    logic [AW:0]      r_count;

    logic             w_wr_ok;
    logic             w_iss_ok;
    logic             w_stall;
    logic             w_inc;
    logic             w_dec;
    logic             w_hit1;
    logic             w_hit2;
    logic             w_zero1;
    logic             w_zero2;
    logic [DEPTH-1:0] w_pend_nxt;

    always_comb begin
        w_wr_ok = bus.writeEn
                && !(ZERO_REG != 0 && bus.addressw == '0);
        w_stall = bus.issueEn && r_pending[bus.issueAddr];
        w_iss_ok = bus.issueEn && !w_stall
                && !(ZERO_REG != 0 && bus.issueAddr == '0);
    end

    always_comb begin
        w_zero1 = ZERO_REG != 0 && bus.address1 == '0;
        w_zero2 = ZERO_REG != 0 && bus.address2 == '0;
        w_hit1 = BYPASS != 0 && w_wr_ok
               && bus.addressw == bus.address1;
        w_hit2 = BYPASS != 0 && w_wr_ok
               && bus.addressw == bus.address2;
    end

    assign bus.read1 = w_zero1 ? '0
                     : w_hit1  ? bus.writeData
                     : r_regs[bus.address1];
    assign bus.read2 = w_zero2 ? '0
                     : w_hit2  ? bus.writeData
                     : r_regs[bus.address2];

    assign bus.busy1 = !w_zero1 && r_pending[bus.address1] && !w_hit1;
    assign bus.busy2 = !w_zero2 && r_pending[bus.address2] && !w_hit2;

    assign bus.issueStall   = w_stall;
    assign bus.pendingCount = r_count;

    // Set is applied after clear so a same-edge issue keeps the bit.
    always_comb begin
        w_pend_nxt = r_pending;
        if (w_wr_ok) w_pend_nxt[bus.addressw] = 1'b0;
        if (w_iss_ok) w_pend_nxt[bus.issueAddr] = 1'b1;
    end

    always_comb begin
        w_inc = w_iss_ok && !r_pending[bus.issueAddr];
        w_dec = w_wr_ok && r_pending[bus.addressw]
              && !(w_iss_ok && bus.issueAddr == bus.addressw);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[bus.addressw] <= bus.writeData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_count   <= '0;
        end else begin
            r_pending <= w_pend_nxt;
            r_count   <= r_count + (AW+1)'(w_inc) - (AW+1)'(w_dec);
        end
    end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised integer register file for the pipelined RISC-V core, replacing the single-cycle register file. It keeps two asynchronous read ports and one synchronous write port, and adds four things: synchronous reset of all registers, optional write-to-read bypass, a configurable hardwired-zero register, and a per-register pending-write scoreboard. The scoreboard lets decode detect RAW and WAW hazards against in-flight instructions. It sits between decode (read/issue side) and writeback (write side).

## Interface
Parameters:
- DEPTH, 32, number of architectural registers; power of two, ≥ 2.
- BITS, 64, register width.
- BYPASS, 1, 1 = a same-cycle write is visible on the read ports and clears busy; 0 = reads return stored state only.
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and is never pending.
- AW (local) = $clog2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- address1  in  AW  read port 1 index.
- address2  in  AW  read port 2 index.
- read1  out  BITS  read port 1 data (combinational).
- read2  out  BITS  read port 2 data (combinational).
- busy1  out  1  register at address1 has an outstanding write.
- busy2  out  1  register at address2 has an outstanding write.
- addressw  in  AW  writeback index.
- writeData  in  BITS  writeback data.
- writeEn  in  1  writeback strobe.
- issueEn  in  1  decode requests to mark issueAddr pending.
- issueAddr  in  AW  destination of the issuing instruction.
- issueStall  out  1  issue refused this cycle (WAW hazard).
- pendingCount  out  AW+1  number of registers currently pending.

## Operation
- Storage: DEPTH×BITS array `regs` plus DEPTH-bit vector `pending`.
- wr_ok = writeEn && !(ZERO_REG && addressw==0).
- Write: on a clock edge with wr_ok, regs[addressw] ← writeData and pending[addressw] ← 0.
- Read N:
  - ZERO_REG && addressN==0 → 0.
  - Else BYPASS && wr_ok && addressw==addressN → writeData.
  - Else regs[addressN].
- busyN = pending[addressN] && !(BYPASS && wr_ok && addressw==addressN). busyN is forced to 0 for register 0 when ZERO_REG.
- issueStall = issueEn && pending[issueAddr]. This is combinational and uses the current pending bit without any bypass clearing. A WAW issue always waits one cycle after its writeback.
- Issue accept: iss_ok = issueEn && !issueStall && !(ZERO_REG && issueAddr==0). On iss_ok, pending[issueAddr] ← 1.
- Issue and writeback to the same register in the same edge: set wins; pending stays 1.
- A writeback to a register that is not pending still writes data; pending stays 0.
- pendingCount is a registered counter updated each edge:
  - +1 if iss_ok sets a bit that was 0.
  - −1 if wr_ok clears a bit that was 1 and iss_ok does not set that same bit.
  - Both, on different registers, → net 0.
- pendingCount always equals popcount(pending). It never exceeds DEPTH, or DEPTH−1 when ZERO_REG.

## Timing
- Reset: while rst is high at an edge, all regs ← 0, pending ← 0, pendingCount ← 0. writeEn and issueEn are ignored that cycle.
- From the cycle after reset:
  - read1/read2 = 0 (or bypassed writeData when BYPASS and writeEn is active).
  - busy1/busy2 = 0.
  - issueStall = 0.
  - pendingCount = 0.
- Reset asserted mid-operation discards all pending bits and data in the same edge.
- Read latency: 0 cycles (combinational).
- Write latency: visible on reads in the same cycle when BYPASS=1, otherwise the next cycle.
- Issue → busy visible the cycle after the accepting edge.
- Writeback clears busy combinationally in the same cycle when BYPASS=1; the stored pending bit clears at that edge.
- No combinational path from issueEn/issueAddr to read1/read2 or busyN.

## Test plan
- Reset then read: assert rst for 1 cycle with writeEn=1, addressw=5, writeData=0xAA → regs[5] stays 0; read1 (address1=5) = 0; pendingCount = 0.
- Write/read with bypass: BYPASS=1; writeEn=1, addressw=3, writeData=0x1234, address1=3 → read1 = 0x1234 in the same cycle. After the edge, with writeEn=0 → read1 = 0x1234. Repeat with BYPASS=0 → the same-cycle read is the old value 0.
- Zero register: write 0xFFFF to addressw=0 → read1 (address1=0) = 0. Issue to 0 → pendingCount stays 0, busy1 = 0, issueStall = 0.
- RAW scoreboard: issue x7 → next cycle busy2 (address2=7) = 1 and pendingCount = 1. Writeback x7 = 0x55 with BYPASS=1 → busy2 = 0 and read2 = 0x55 in that cycle. Next cycle pendingCount = 0.
- WAW and simultaneous events:
  - With x9 pending, issueEn on x9 → issueStall = 1 and pendingCount unchanged.
  - Issue x4 and writeback x4 on the same edge with x4 not pending → x4 pending, pendingCount +1.
  - Issue x2 and writeback pending x6 on the same edge → count unchanged.
- Fill and reset mid-flight: issue x1..x31 → pendingCount = 31. Assert rst → next cycle pendingCount = 0 and all busy = 0.
